sel4to2_enc: RTL
================

# sel4to2_enc

Request encoder and arbiter that performs the inverse of the select-to-path decoder. It takes four request lines, one per path, and produces the 2-bit path index that a downstream decoder consumes. The block grants one request at a time, registers the result, and holds it under a valid/ready handshake until the consumer accepts it. It sits between the path request sources and the select input of the decoder.

## Interface
Parameters:
- CNT_W, default 8: width of the completed-transfer counter.

Ports:
- clk1, input, 1: sole clock; all state changes on the rising edge.
- rst1, input, 1: reset, asynchronous, active-high.
- path_req, input, 4: level request lines; bit i requests path i.
- select, output, 2: granted path index (0..3); registered.
- sel_valid, output, 1: select holds a grant not yet accepted; registered.
- sel_ready, input, 1: consumer accepts the grant when high in the same cycle as sel_valid.
- multi_req, output, 1: the grant was chosen from more than one asserted request; registered, and valid only while sel_valid is high.
- grant_cnt, output, CNT_W: number of completed transfers, modulo 2^CNT_W.

## Operation
- State machine with two states:
  - IDLE: no grant outstanding.
  - VALID: grant presented.
- IDLE:
  - If path_req != 0 at the edge, compute the grant from path_req and the current priority.
  - Load select, set sel_valid=1, set multi_req=(popcount(path_req)>1), and go to VALID.
  - Otherwise stay in IDLE with sel_valid=0.
- VALID:
  - select and multi_req are frozen. path_req changes are ignored until transfer.
  - A transfer occurs on an edge where sel_valid=1 and sel_ready=1. On transfer:
    - grant_cnt increments, wrapping from all-ones to 0.
    - The priority pointer updates (round-robin build only).
    - If path_req != 0 in the same cycle, a new grant is computed using the updated pointer. select and multi_req are reloaded, and the block stays in VALID with no bubble.
    - Otherwise the block goes to IDLE and sel_valid=0.
- sel_ready is ignored while sel_valid=0.
- Grant rule, fixed-priority build: lowest asserted index wins.
- Grant rule, round-robin build:
  - The search starts at pointer ptr (2 bits) and scans ptr, ptr+1, ptr+2, ptr+3, all modulo 4. The first asserted bit wins.
  - On transfer, ptr = select+1 modulo 4. Index 3 wraps to 0.
- Reset values: select=2'b00, sel_valid=0, multi_req=0, grant_cnt=0, ptr=0, state=IDLE.
- Reset asserted mid-operation clears everything immediately, without waiting for a clock edge. Any pending grant is discarded and not counted.

## Timing
- Request to sel_valid: 1 cycle (request sampled at edge N, sel_valid high after edge N).
- Minimum grant hold is 1 cycle. Throughput is one grant per cycle when sel_ready is held high and requests stay asserted.
- All outputs are registered. There is no combinational path from path_req or sel_ready to any output.
- Release of rst1 is synchronised by the user. The first possible grant appears 1 cycle after the first edge with rst1 low.

## Configuration
- SEL4TO2_RR_EN:
  - Defined: round-robin arbitration using ptr, as described in Operation.
  - Undefined: fixed priority (index 0 highest). ptr logic is not built, and grant order depends only on path_req.
- All other behaviour is identical in both builds.

## Test plan
- Reset:
  - Assert rst1 between edges. select=00, sel_valid=0, multi_req=0 and grant_cnt=0 must take effect immediately, without a clock edge.
  - Release rst1 with path_req=0. Outputs stay at reset values.
- Single request with backpressure:
  - path_req=4'b0100, sel_ready=0 for 3 cycles. One cycle later select=10, sel_valid=1, multi_req=0.
  - select stays stable for all 3 cycles, even if path_req changes to 4'b0001.
  - Raise sel_ready: grant_cnt=1. The next grant is select=00.
- Multiple requests, fixed priority (macro undefined):
  - path_req=4'b1010, sel_ready=1. Every grant is select=01 with multi_req=1.
- Multiple requests, round-robin (macro defined):
  - path_req=4'b1111, sel_ready=1 held. select sequence is 00,01,10,11,00 on consecutive cycles with sel_valid continuously high.
  - path_req=4'b1010: the sequence alternates 01,11.
- Counter wrap:
  - CNT_W=2 with 5 accepted transfers. grant_cnt goes 1,2,3,0,1.
- Reset while busy:
  - Assert rst1 while sel_valid=1. sel_valid, select and grant_cnt clear immediately.
  - After release, ptr=0, so with 4'b1111 the first grant is 00.

Source files
------------

// File: rtl/sel4to2_enc_if.sv
// Request/grant bus between the path request sources, sel4to2_enc and the select decoder.
// Handshake: a grant transfers on a rising edge where sel_valid and sel_ready are both high; select/multi_req hold until then.
interface sel4to2_enc_if #(
  parameter int CNT_W = 8
);
  logic [3:0]       path_req;
  logic [1:0]       select;
  logic             sel_valid;
  logic             sel_ready;
  logic             multi_req;
  logic [CNT_W-1:0] grant_cnt;

  modport master (
    input  path_req,
    input  sel_ready,
    output select,
    output sel_valid,
    output multi_req,
    output grant_cnt
  );

  modport slave (
    output path_req,
    output sel_ready,
    input  select,
    input  sel_valid,
    input  multi_req,
    input  grant_cnt
  );
endinterface

// File: rtl/sel4to2_enc.sv
// Four-way request encoder/arbiter presenting a registered 2-bit path index under valid/ready.
// Define SEL4TO2_RR_EN for round-robin arbitration; otherwise index 0 has fixed highest priority.
module sel4to2_enc #(
  parameter int CNT_W = 8
) (
  input  logic              clk1,
  input  logic              rst1,
  sel4to2_enc_if.master     bus,
  output logic              state_dbg
);

  typedef enum logic {
    IDLE  = 1'b0,
    VALID = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             load;
  logic             xfer;
  logic [1:0]       sel_r;
  logic             multi_r;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       scan_base;
  logic [1:0]       grant;
  logic [1:0]       idx;
  logic             found;
  logic             multi;

  // Next state plus the two strobes that drive every register update.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    xfer      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.path_req != 4'b0000) begin
          load      = 1'b1;
          state_nxt = VALID;
        end
      end
      VALID: begin
        if (bus.sel_ready) begin
          xfer = 1'b1;
          if (bus.path_req != 4'b0000) begin
            load = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef SEL4TO2_RR_EN
  logic [1:0] ptr;

  // A back-to-back grant must already see the pointer advanced past the one being accepted.
  assign scan_base = xfer ? (sel_r + 2'd1) : ptr;

  always_ff @(posedge clk1 or posedge rst1) begin
    if (rst1) begin
      ptr <= 2'd0;
    end else if (xfer) begin
      ptr <= sel_r + 2'd1;
    end
  end
`else
  assign scan_base = 2'd0;
`endif

  // First asserted request scanning upward (modulo 4) from scan_base.
  always_comb begin
    grant = 2'd0;
    found = 1'b0;
    idx   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = scan_base + 2'(k);
      if (!found && bus.path_req[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end

  assign multi = ($countones(bus.path_req) > 1);

  always_ff @(posedge clk1 or posedge rst1) begin
    if (rst1) begin
      state   <= IDLE;
      sel_r   <= 2'd0;
      multi_r <= 1'b0;
      cnt     <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        sel_r   <= grant;
        multi_r <= multi;
      end else if (xfer) begin
        multi_r <= 1'b0;
      end
      if (xfer) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign bus.select    = sel_r;
  assign bus.sel_valid = (state == VALID);
  assign bus.multi_req = multi_r;
  assign bus.grant_cnt = cnt;
  assign state_dbg     = state;

endmodule
